// File: rtl/spi_burst_fsm.sv
// Purpose     : SPI slave register-file control FSM; decodes an ADDR_BITS+rw header per
//               chip-select frame, then runs single or auto-incrementing burst reads/writes.
// Latency     : registered outputs decoded from next state; a word ends one clk after its last sclk_pos.
// Backpressure: none; the SPI master owns the pace, and cs high aborts any state at once.
// Ports:
//   clk, reset_n      system clock, asynchronous active-low reset
//   cs                synchronised chip select, active low
//   sclk_pos          one-clk pulse per SCLK rising edge
//   rw                header rw bit from the shift register (1 = read), sampled in LATCH
//   sr_we, dm_we      shift-register parallel load / data-memory write strobes
//   addr_we, addr_inc address latch load / increment strobes
//   miso_en, busy     MISO drive enable, FSM not idle
module spi_burst_fsm #(
    parameter int ADDR_BITS = 7,
    parameter int DATA_BITS = 8,
    parameter int RD_LAT    = 1,
    parameter int BURST_EN  = 1,
    parameter int MAX_BURST = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic cs,
    input  logic sclk_pos,
    input  logic rw,
    output logic sr_we,
    output logic dm_we,
    output logic addr_we,
    output logic addr_inc,
    output logic miso_en,
    output logic busy
);

    localparam int HDR    = ADDR_BITS + 1;
    localparam int BC_MAX = (HDR > DATA_BITS) ? HDR : DATA_BITS;
    localparam int BC_W   = $clog2(BC_MAX + 1);
    localparam int WC_W   = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

    localparam logic [BC_W-1:0] HDR_CNT  = BC_W'(HDR);
    localparam logic [BC_W-1:0] DATA_CNT = BC_W'(DATA_BITS);
    localparam logic [1:0]      LAT_LAST = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;
    // Word count value at which the word now finishing is the last allowed one.
    localparam logic [WC_W-1:0] LAST_WC  = (MAX_BURST > 0) ? WC_W'(MAX_BURST - 1) : '0;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR,
        S_LATCH,
        S_RD_WAIT,
        S_RD_LOAD,
        S_RD_SHIFT,
        S_WR_SHIFT,
        S_WR_COMMIT,
        S_DONE
    } state_t;

    // With zero read latency the wait state is skipped entirely.
    localparam state_t RD_FIRST = (RD_LAT == 0) ? S_RD_LOAD : S_RD_WAIT;

    state_t          state, state_nxt;
    logic [BC_W-1:0] bcnt, bcnt_nxt;
    logic [WC_W-1:0] wcnt, wcnt_nxt;
    logic [1:0]      lat, lat_nxt;
    logic            inc_nxt;
    logic            count_en;
    logic            burst_ok;

    always_comb begin
        state_nxt = state;
        bcnt_nxt  = bcnt;
        wcnt_nxt  = wcnt;
        lat_nxt   = lat;
        inc_nxt   = 1'b0;
        count_en  = sclk_pos && ((state == S_HDR) || (state == S_RD_WAIT) ||
                                 (state == S_RD_LOAD) || (state == S_RD_SHIFT) ||
                                 (state == S_WR_SHIFT));
        burst_ok  = (BURST_EN != 0) && !((MAX_BURST != 0) && (wcnt == LAST_WC));

        if (cs) begin
            // Deselect wins over everything, including a coincident sclk_pos.
            state_nxt = S_IDLE;
            bcnt_nxt  = '0;
            wcnt_nxt  = '0;
            lat_nxt   = '0;
        end else begin
            if (count_en) begin
                bcnt_nxt = bcnt + BC_W'(1);
            end
            case (state)
                S_IDLE: begin
                    state_nxt = S_HDR;
                    bcnt_nxt  = '0;
                    wcnt_nxt  = '0;
                end
                S_HDR: begin
                    if (bcnt == HDR_CNT) begin
                        state_nxt = S_LATCH;
                        bcnt_nxt  = '0;
                    end
                end
                S_LATCH: begin
                    state_nxt = rw ? RD_FIRST : S_WR_SHIFT;
                    lat_nxt   = '0;
                end
                S_RD_WAIT: begin
                    if (lat == LAT_LAST) begin
                        state_nxt = S_RD_LOAD;
                    end else begin
                        lat_nxt = lat + 2'd1;
                    end
                end
                S_RD_LOAD: begin
                    state_nxt = S_RD_SHIFT;
                end
                S_RD_SHIFT: begin
                    if (bcnt == DATA_CNT) begin
                        bcnt_nxt = '0;
                        wcnt_nxt = wcnt + WC_W'(1);
                        if (burst_ok) begin
                            state_nxt = RD_FIRST;
                            lat_nxt   = '0;
                            inc_nxt   = 1'b1;
                        end else begin
                            state_nxt = S_DONE;
                        end
                    end
                end
                S_WR_SHIFT: begin
                    if (bcnt == DATA_CNT) begin
                        state_nxt = S_WR_COMMIT;
                        bcnt_nxt  = '0;
                        wcnt_nxt  = wcnt + WC_W'(1);
                        inc_nxt   = burst_ok;
                    end
                end
                S_WR_COMMIT: begin
                    // addr_inc was raised on entry exactly when another word may follow.
                    state_nxt = addr_inc ? S_WR_SHIFT : S_DONE;
                end
                S_DONE: begin
                    state_nxt = S_DONE;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            bcnt     <= '0;
            wcnt     <= '0;
            lat      <= '0;
            sr_we    <= 1'b0;
            dm_we    <= 1'b0;
            addr_we  <= 1'b0;
            addr_inc <= 1'b0;
            miso_en  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            bcnt     <= bcnt_nxt;
            wcnt     <= wcnt_nxt;
            lat      <= lat_nxt;
            sr_we    <= (state_nxt == S_RD_LOAD);
            dm_we    <= (state_nxt == S_WR_COMMIT);
            addr_we  <= (state_nxt == S_LATCH);
            addr_inc <= inc_nxt;
            miso_en  <= (state_nxt == S_RD_SHIFT);
            busy     <= (state_nxt != S_IDLE);
        end
    end

endmodule

// File: tb/tb_spi_burst_fsm.sv
// Purpose     : scoreboard bench for spi_burst_fsm across four parameter sets.
// Latency     : expected events carry the absolute clk cycle they must appear on.
// Backpressure: n/a; the bench drives sclk_pos at one pulse per four clks.
module tb_spi_burst_fsm;

    localparam logic [5:0] BSY = 6'b100000;
    localparam logic [5:0] MIS = 6'b010000;
    localparam logic [5:0] AW  = 6'b001000;
    localparam logic [5:0] SR  = 6'b000100;
    localparam logic [5:0] DM  = 6'b000010;
    localparam logic [5:0] INC = 6'b000001;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] cs, sclk_pos, rw;
    logic [3:0] sr_we, dm_we, addr_we, addr_inc, miso_en, busy;

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // 0: defaults, 1: single word, 2: two-word burst limit, 3: wide/slow memory
    spi_burst_fsm u_def (
        .clk(clk), .reset_n(reset_n), .cs(cs[0]), .sclk_pos(sclk_pos[0]), .rw(rw[0]),
        .sr_we(sr_we[0]), .dm_we(dm_we[0]), .addr_we(addr_we[0]), .addr_inc(addr_inc[0]),
        .miso_en(miso_en[0]), .busy(busy[0]));
    spi_burst_fsm #(.BURST_EN(0)) u_nb (
        .clk(clk), .reset_n(reset_n), .cs(cs[1]), .sclk_pos(sclk_pos[1]), .rw(rw[1]),
        .sr_we(sr_we[1]), .dm_we(dm_we[1]), .addr_we(addr_we[1]), .addr_inc(addr_inc[1]),
        .miso_en(miso_en[1]), .busy(busy[1]));
    spi_burst_fsm #(.MAX_BURST(2)) u_mb2 (
        .clk(clk), .reset_n(reset_n), .cs(cs[2]), .sclk_pos(sclk_pos[2]), .rw(rw[2]),
        .sr_we(sr_we[2]), .dm_we(dm_we[2]), .addr_we(addr_we[2]), .addr_inc(addr_inc[2]),
        .miso_en(miso_en[2]), .busy(busy[2]));
    spi_burst_fsm #(.ADDR_BITS(10), .DATA_BITS(16), .RD_LAT(3)) u_wide (
        .clk(clk), .reset_n(reset_n), .cs(cs[3]), .sclk_pos(sclk_pos[3]), .rw(rw[3]),
        .sr_we(sr_we[3]), .dm_we(dm_we[3]), .addr_we(addr_we[3]), .addr_inc(addr_inc[3]),
        .miso_en(miso_en[3]), .busy(busy[3]));

    typedef struct packed {
        logic [31:0] cyc;
        logic [5:0]  vec;
    } ev_t;

    ev_t q0[$], q1[$], q2[$], q3[$];
    logic [5:0] mon_prev [4];

    function automatic logic [5:0] outv(int d);
        return {busy[d], miso_en[d], addr_we[d], sr_we[d], dm_we[d], addr_inc[d]};
    endfunction

    task automatic expect_ev(int d, int unsigned t0, int off, logic [5:0] v);
        ev_t e;
        e.cyc = t0 + off;
        e.vec = v;
        case (d)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    function automatic int q_size(int d);
        case (d)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic ev_t q_pop(int d);
        case (d)
            0: return q0.pop_front();
            1: return q1.pop_front();
            2: return q2.pop_front();
            default: return q3.pop_front();
        endcase
    endfunction

    task automatic check_vec(string name, int d, logic [5:0] want);
        n_checks++;
        if (outv(d) !== want) begin
            n_errors++;
            $display("FAIL %s dut%0d: got %b want %b", name, d, outv(d), want);
        end
    endtask

    // Monitor: any strobe, or a busy/miso_en level change, is an event to score.
    initial begin
        for (int d = 0; d < 4; d++) mon_prev[d] = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 4; d++) begin
                logic [5:0] cur;
                ev_t        e;
                cur = outv(d);
                if (reset_n && ((cur[3:0] != 4'b0) || (cur[5:4] != mon_prev[d][5:4]))) begin
                    n_checks++;
                    if (q_size(d) == 0) begin
                        n_errors++;
                        $display("FAIL dut%0d unexpected event: got %b at cycle %0d, none expected",
                                 d, cur, cyc);
                    end else begin
                        e = q_pop(d);
                        if ((e.cyc != cyc) || (e.vec != cur)) begin
                            n_errors++;
                            $display("FAIL dut%0d event: got %b at cycle %0d, want %b at cycle %0d",
                                     d, cur, cyc, e.vec, e.cyc);
                        end
                    end
                end
                mon_prev[d] = cur;
            end
        end
    end

    task automatic start_frame(int d, logic rw_v, output int unsigned t0);
        @(negedge clk);
        cs[d] = 1'b0;
        rw[d] = rw_v;
        t0    = cyc + 1;
    endtask

    // Pulse i (1-based) of a frame is sampled on the (4i-3)th clk after frame start.
    task automatic pulses(int d, int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sclk_pos[d] = 1'b1;
            @(negedge clk);
            sclk_pos[d] = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic end_frame(int d);
        @(negedge clk);
        cs[d] = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int unsigned t0;
        reset_n  = 1'b0;
        cs       = 4'hF;
        sclk_pos = 4'h0;
        rw       = 4'h0;
        #3;
        for (int d = 0; d < 4; d++) check_vec("reset_state", d, 6'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single-word read, no burst: 8 header + 8 data pulses.
        start_frame(1, 1'b1, t0);
        expect_ev(1, t0, 0,  BSY);
        expect_ev(1, t0, 30, BSY | AW);
        expect_ev(1, t0, 32, BSY | SR);
        expect_ev(1, t0, 33, BSY | MIS);
        expect_ev(1, t0, 62, BSY);
        expect_ev(1, t0, 65, 6'b0);
        pulses(1, 16);
        end_frame(1);

        // Unlimited burst write: three words.
        start_frame(0, 1'b0, t0);
        expect_ev(0, t0, 0,   BSY);
        expect_ev(0, t0, 30,  BSY | AW);
        expect_ev(0, t0, 62,  BSY | DM | INC);
        expect_ev(0, t0, 94,  BSY | DM | INC);
        expect_ev(0, t0, 126, BSY | DM | INC);
        expect_ev(0, t0, 129, 6'b0);
        pulses(0, 32);
        end_frame(0);

        // Read capped at two words; the remaining 24 pulses are ignored in DONE.
        start_frame(2, 1'b1, t0);
        expect_ev(2, t0, 0,   BSY);
        expect_ev(2, t0, 30,  BSY | AW);
        expect_ev(2, t0, 32,  BSY | SR);
        expect_ev(2, t0, 33,  BSY | MIS);
        expect_ev(2, t0, 62,  BSY | INC);
        expect_ev(2, t0, 63,  BSY | SR);
        expect_ev(2, t0, 64,  BSY | MIS);
        expect_ev(2, t0, 94,  BSY);
        expect_ev(2, t0, 193, 6'b0);
        pulses(2, 48);
        end_frame(2);

        // Write aborted after 5 data bits: no commit.
        start_frame(0, 1'b0, t0);
        expect_ev(0, t0, 0,  BSY);
        expect_ev(0, t0, 30, BSY | AW);
        expect_ev(0, t0, 53, 6'b0);
        pulses(0, 13);
        end_frame(0);

        // Wide header, 16-bit words, 3-cycle read latency.
        start_frame(3, 1'b1, t0);
        expect_ev(3, t0, 0,   BSY);
        expect_ev(3, t0, 42,  BSY | AW);
        expect_ev(3, t0, 46,  BSY | SR);
        expect_ev(3, t0, 47,  BSY | MIS);
        expect_ev(3, t0, 106, BSY | INC);
        expect_ev(3, t0, 109, 6'b0);
        pulses(3, 27);
        end_frame(3);

        // Async reset in the middle of a read shift, then a fresh frame with cs held low.
        start_frame(0, 1'b1, t0);
        expect_ev(0, t0, 0,  BSY);
        expect_ev(0, t0, 30, BSY | AW);
        expect_ev(0, t0, 32, BSY | SR);
        expect_ev(0, t0, 33, BSY | MIS);
        pulses(0, 11);
        #2;
        reset_n = 1'b0;
        #1;
        check_vec("async_reset", 0, 6'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        t0 = cyc + 1;
        expect_ev(0, t0, 0,  BSY);
        expect_ev(0, t0, 30, BSY | AW);
        expect_ev(0, t0, 32, BSY | SR);
        expect_ev(0, t0, 33, BSY | MIS);
        expect_ev(0, t0, 37, 6'b0);
        pulses(0, 9);
        end_frame(0);

        repeat (10) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            n_checks++;
            if (q_size(d) != 0) begin
                n_errors++;
                $display("FAIL dut%0d missing events: %0d still pending, want 0", d, q_size(d));
            end
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
